// File: rtl/eth_frame_arb.sv
// ---------------------------------------------------------------------------
// eth_frame_arb
//
// Two-input Ethernet frame arbiter in front of eth_axis_tx. One source is
// granted at a time. The grant is held from the header handshake through the
// payload tlast beat, so frames from the two sources never interleave.
// The header and payload muxes are combinational from the registered grant.
// No data is buffered.
//
// Configuration macro:
//   ETH_ARB_ROUND_ROBIN_EN  defined   -> round-robin on a tie. The port that
//                                        was not granted last wins.
//                           undefined -> fixed priority. Port 0 wins every
//                                        tie.
//
// Parameters:
//   DATA_WIDTH  payload tdata width
//   CNT_WIDTH   width of the per-port completed-frame counters
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   sN_eth_hdr_*      (N = 0, 1)    source header handshake and fields
//   sN_eth_payload_axis_*           source payload stream
//   m_eth_hdr_*                     muxed header towards eth_axis_tx
//   m_eth_payload_axis_*            muxed payload towards eth_axis_tx
//   grant                           one-hot active grant, 00 when idle
//   busy                            high while a frame is in progress
//   frame_cnt0, frame_cnt1          completed frames per port, wrapping
// ---------------------------------------------------------------------------
module eth_frame_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  s0_eth_hdr_valid,
   output logic                  s0_eth_hdr_ready,
   input  logic [47:0]           s0_eth_dest_mac,
   input  logic [47:0]           s0_eth_src_mac,
   input  logic [15:0]           s0_eth_type,
   input  logic [DATA_WIDTH-1:0] s0_eth_payload_axis_tdata,
   input  logic                  s0_eth_payload_axis_tvalid,
   input  logic                  s0_eth_payload_axis_tlast,
   input  logic                  s0_eth_payload_axis_tuser,
   output logic                  s0_eth_payload_axis_tready,

   input  logic                  s1_eth_hdr_valid,
   output logic                  s1_eth_hdr_ready,
   input  logic [47:0]           s1_eth_dest_mac,
   input  logic [47:0]           s1_eth_src_mac,
   input  logic [15:0]           s1_eth_type,
   input  logic [DATA_WIDTH-1:0] s1_eth_payload_axis_tdata,
   input  logic                  s1_eth_payload_axis_tvalid,
   input  logic                  s1_eth_payload_axis_tlast,
   input  logic                  s1_eth_payload_axis_tuser,
   output logic                  s1_eth_payload_axis_tready,

   output logic                  m_eth_hdr_valid,
   input  logic                  m_eth_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [47:0]           m_eth_src_mac,
   output logic [15:0]           m_eth_type,
   output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
   output logic                  m_eth_payload_axis_tvalid,
   output logic                  m_eth_payload_axis_tlast,
   output logic                  m_eth_payload_axis_tuser,
   input  logic                  m_eth_payload_axis_tready,

   output logic [1:0]            grant,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  frame_cnt0,
   output logic [CNT_WIDTH-1:0]  frame_cnt1
);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD
   } state_t;

   state_t               state, state_next;
   logic [1:0]           grant_reg, grant_next;
   logic                 last_grant, last_grant_next;
   logic                 win_port;
   logic                 sel;
   logic                 sel_hdr_valid;
   logic                 sel_tvalid;
   logic                 sel_tlast;
   logic                 sel_tuser;
   logic                 inc0, inc1;
   logic [CNT_WIDTH-1:0] cnt0, cnt1;

   // sel is the granted port index. When idle the grant is 00, so sel
   // points at port 0, but every valid and ready is gated by state anyway.
   assign sel           = grant_reg[1];
   assign sel_hdr_valid = sel ? s1_eth_hdr_valid           : s0_eth_hdr_valid;
   assign sel_tvalid    = sel ? s1_eth_payload_axis_tvalid : s0_eth_payload_axis_tvalid;
   assign sel_tlast     = sel ? s1_eth_payload_axis_tlast  : s0_eth_payload_axis_tlast;
   assign sel_tuser     = sel ? s1_eth_payload_axis_tuser  : s0_eth_payload_axis_tuser;

   assign grant      = grant_reg;
   assign busy       = (state != IDLE);
   assign frame_cnt0 = cnt0;
   assign frame_cnt1 = cnt1;

   // Winner among the current header requests (1 = port 1). Only used in
   // IDLE, when at least one request is present.
   always_comb begin
`ifdef ETH_ARB_ROUND_ROBIN_EN
      if (s0_eth_hdr_valid && s1_eth_hdr_valid) begin
         win_port = ~last_grant;
      end else begin
         win_port = ~s0_eth_hdr_valid;
      end
`else
      win_port = ~s0_eth_hdr_valid;
`endif
   end

   // Next-state logic and all muxed outputs. Non-granted ports never see a
   // ready. The master side only sees a valid in the phase that matches it.
   always_comb begin
      state_next                 = state;
      grant_next                 = grant_reg;
      last_grant_next            = last_grant;
      inc0                       = 1'b0;
      inc1                       = 1'b0;
      s0_eth_hdr_ready           = 1'b0;
      s1_eth_hdr_ready           = 1'b0;
      s0_eth_payload_axis_tready = 1'b0;
      s1_eth_payload_axis_tready = 1'b0;
      m_eth_hdr_valid            = 1'b0;
      m_eth_dest_mac             = sel ? s1_eth_dest_mac : s0_eth_dest_mac;
      m_eth_src_mac              = sel ? s1_eth_src_mac  : s0_eth_src_mac;
      m_eth_type                 = sel ? s1_eth_type     : s0_eth_type;
      m_eth_payload_axis_tdata   = sel ? s1_eth_payload_axis_tdata : s0_eth_payload_axis_tdata;
      m_eth_payload_axis_tvalid  = 1'b0;
      m_eth_payload_axis_tlast   = 1'b0;
      m_eth_payload_axis_tuser   = 1'b0;

      case (state)
         IDLE: begin
            if (s0_eth_hdr_valid || s1_eth_hdr_valid) begin
               grant_next = win_port ? 2'b10 : 2'b01;
               state_next = HDR;
            end
         end

         HDR: begin
            m_eth_hdr_valid = sel_hdr_valid;
            if (sel) begin
               s1_eth_hdr_ready = m_eth_hdr_ready;
            end else begin
               s0_eth_hdr_ready = m_eth_hdr_ready;
            end
            if (sel_hdr_valid && m_eth_hdr_ready) begin
               state_next = PAYLOAD;
            end
         end

         PAYLOAD: begin
            m_eth_payload_axis_tvalid = sel_tvalid;
            m_eth_payload_axis_tlast  = sel_tlast;
            m_eth_payload_axis_tuser  = sel_tuser;
            if (sel) begin
               s1_eth_payload_axis_tready = m_eth_payload_axis_tready;
            end else begin
               s0_eth_payload_axis_tready = m_eth_payload_axis_tready;
            end
            // An errored frame (tuser) still counts and still ends the grant.
            if (sel_tvalid && m_eth_payload_axis_tready && sel_tlast) begin
               inc0            = ~sel;
               inc1            = sel;
               last_grant_next = sel;
               grant_next      = 2'b00;
               state_next      = IDLE;
            end
         end

         default: begin
            grant_next = 2'b00;
            state_next = IDLE;
         end
      endcase
   end

   // State, grant and last-grant registers. After reset, last_grant points
   // at port 1, so port 0 wins the first round-robin tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_reg  <= 2'b00;
         last_grant <= 1'b1;
      end else begin
         state      <= state_next;
         grant_reg  <= grant_next;
         last_grant <= last_grant_next;
      end
   end

   // Completed-frame counters. They step in the cycle after the tlast beat
   // and wrap naturally at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (inc0) begin
            cnt0 <= cnt0 + CNT_WIDTH'(1);
         end
         if (inc1) begin
            cnt1 <= cnt1 + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_arb.sv
// ---------------------------------------------------------------------------
// tb_eth_frame_arb
//
// Scoreboard bench for eth_frame_arb. It runs a directed reset and
// latency section, then random traffic from both sources. The expected
// headers and beats are queued per port when each frame is issued. A monitor
// pops and compares them as the master side accepts each item. The monitor
// also predicts every grant from the arbitration rule and tracks the
// per-port frame counts.
// ---------------------------------------------------------------------------
module tb_eth_frame_arb;

   localparam int DW        = 8;
   localparam int CW        = 2;
   localparam int CNT_MOD   = 1 << CW;
   localparam int NFRAMES   = 10;
   localparam int STIM_MAX  = 20000;
   localparam int DRAIN_MAX = 2000;

   typedef struct packed {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] etype;
   } hdr_t;

   logic clk;
   logic rst;

   logic          s0_eth_hdr_valid, s0_eth_hdr_ready;
   logic [47:0]   s0_eth_dest_mac, s0_eth_src_mac;
   logic [15:0]   s0_eth_type;
   logic [DW-1:0] s0_eth_payload_axis_tdata;
   logic          s0_eth_payload_axis_tvalid, s0_eth_payload_axis_tlast;
   logic          s0_eth_payload_axis_tuser, s0_eth_payload_axis_tready;
   logic          s1_eth_hdr_valid, s1_eth_hdr_ready;
   logic [47:0]   s1_eth_dest_mac, s1_eth_src_mac;
   logic [15:0]   s1_eth_type;
   logic [DW-1:0] s1_eth_payload_axis_tdata;
   logic          s1_eth_payload_axis_tvalid, s1_eth_payload_axis_tlast;
   logic          s1_eth_payload_axis_tuser, s1_eth_payload_axis_tready;
   logic          m_eth_hdr_valid, m_eth_hdr_ready;
   logic [47:0]   m_eth_dest_mac, m_eth_src_mac;
   logic [15:0]   m_eth_type;
   logic [DW-1:0] m_eth_payload_axis_tdata;
   logic          m_eth_payload_axis_tvalid, m_eth_payload_axis_tlast;
   logic          m_eth_payload_axis_tuser, m_eth_payload_axis_tready;
   logic [1:0]    grant;
   logic          busy;
   logic [CW-1:0] frame_cnt0, frame_cnt1;

   // Per-port source drive state
   logic          drv_hv[2];
   logic [47:0]   drv_dest[2];
   logic [47:0]   drv_src[2];
   logic [15:0]   drv_type[2];
   logic [DW-1:0] drv_data[2];
   logic          drv_tv[2];
   logic          drv_tl[2];
   logic          drv_tu[2];
   int            phase[2];
   int            gap[2];
   int            frames_left[2];
   int            frame_idx[2];
   logic [DW+1:0] cur_q[2][$];

   // Scoreboard
   hdr_t          exp_hdr_q[2][$];
   logic [DW+1:0] exp_pay_q[2][$];
   int            done_cnt[2];
   int            last_winner;
   bit            mon_en;
   bit            stim_done;
   bit            stim_ok;
   bit            post_last;
   int            n_cmp;
   int            n_bad;

   assign s0_eth_hdr_valid           = drv_hv[0];
   assign s0_eth_dest_mac            = drv_dest[0];
   assign s0_eth_src_mac             = drv_src[0];
   assign s0_eth_type                = drv_type[0];
   assign s0_eth_payload_axis_tdata  = drv_data[0];
   assign s0_eth_payload_axis_tvalid = drv_tv[0];
   assign s0_eth_payload_axis_tlast  = drv_tl[0];
   assign s0_eth_payload_axis_tuser  = drv_tu[0];
   assign s1_eth_hdr_valid           = drv_hv[1];
   assign s1_eth_dest_mac            = drv_dest[1];
   assign s1_eth_src_mac             = drv_src[1];
   assign s1_eth_type                = drv_type[1];
   assign s1_eth_payload_axis_tdata  = drv_data[1];
   assign s1_eth_payload_axis_tvalid = drv_tv[1];
   assign s1_eth_payload_axis_tlast  = drv_tl[1];
   assign s1_eth_payload_axis_tuser  = drv_tu[1];

   eth_frame_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .s0_eth_hdr_valid           (s0_eth_hdr_valid),
      .s0_eth_hdr_ready           (s0_eth_hdr_ready),
      .s0_eth_dest_mac            (s0_eth_dest_mac),
      .s0_eth_src_mac             (s0_eth_src_mac),
      .s0_eth_type                (s0_eth_type),
      .s0_eth_payload_axis_tdata  (s0_eth_payload_axis_tdata),
      .s0_eth_payload_axis_tvalid (s0_eth_payload_axis_tvalid),
      .s0_eth_payload_axis_tlast  (s0_eth_payload_axis_tlast),
      .s0_eth_payload_axis_tuser  (s0_eth_payload_axis_tuser),
      .s0_eth_payload_axis_tready (s0_eth_payload_axis_tready),
      .s1_eth_hdr_valid           (s1_eth_hdr_valid),
      .s1_eth_hdr_ready           (s1_eth_hdr_ready),
      .s1_eth_dest_mac            (s1_eth_dest_mac),
      .s1_eth_src_mac             (s1_eth_src_mac),
      .s1_eth_type                (s1_eth_type),
      .s1_eth_payload_axis_tdata  (s1_eth_payload_axis_tdata),
      .s1_eth_payload_axis_tvalid (s1_eth_payload_axis_tvalid),
      .s1_eth_payload_axis_tlast  (s1_eth_payload_axis_tlast),
      .s1_eth_payload_axis_tuser  (s1_eth_payload_axis_tuser),
      .s1_eth_payload_axis_tready (s1_eth_payload_axis_tready),
      .m_eth_hdr_valid            (m_eth_hdr_valid),
      .m_eth_hdr_ready            (m_eth_hdr_ready),
      .m_eth_dest_mac             (m_eth_dest_mac),
      .m_eth_src_mac              (m_eth_src_mac),
      .m_eth_type                 (m_eth_type),
      .m_eth_payload_axis_tdata   (m_eth_payload_axis_tdata),
      .m_eth_payload_axis_tvalid  (m_eth_payload_axis_tvalid),
      .m_eth_payload_axis_tlast   (m_eth_payload_axis_tlast),
      .m_eth_payload_axis_tuser   (m_eth_payload_axis_tuser),
      .m_eth_payload_axis_tready  (m_eth_payload_axis_tready),
      .grant                      (grant),
      .busy                       (busy),
      .frame_cnt0                 (frame_cnt0),
      .frame_cnt1                 (frame_cnt1)
   );

   // 125 MHz system clock
   initial clk = 1'b0;
   always #4 clk = ~clk;

   // Single comparison point. Every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present the head of the port's beat queue. tvalid is randomised here,
   // which is only reached when tvalid is low or a beat was just accepted.
   task automatic nextBeat(input int p);
      logic [DW+1:0] b;
      b          = cur_q[p][0];
      drv_data[p] = b[DW-1:0];
      drv_tu[p]   = b[DW];
      drv_tl[p]   = b[DW+1];
      drv_tv[p]   = ($urandom_range(4) != 0);
   endtask

   // Build a frame and raise its header. The expected header and beats are
   // queued on the scoreboard here, when the stimulus is issued.
   task automatic startFrame(input int p);
      hdr_t          h;
      logic [63:0]   r;
      logic [31:0]   rb;
      logic [DW+1:0] b;
      int            len;
      bit            err;
      r       = {$urandom(), $urandom()};
      h.dest  = r[47:0];
      r       = {$urandom(), $urandom()};
      h.src   = r[47:0];
      rb      = $urandom();
      h.etype = rb[15:0];
      len     = $urandom_range(16, 1);
      if (p == 0 && frame_idx[p] == 0) begin
         h.etype = 16'h88B5;
         len     = 64;
      end
      err = ($urandom_range(3) == 0);
      exp_hdr_q[p].push_back(h);
      for (int i = 0; i < len; i++) begin
         rb = $urandom();
         b  = {(i == len - 1), (err && (i == len - 1)), rb[DW-1:0]};
         cur_q[p].push_back(b);
         exp_pay_q[p].push_back(b);
      end
      drv_dest[p] = h.dest;
      drv_src[p]  = h.src;
      drv_type[p] = h.etype;
      drv_hv[p]   = 1'b1;
      phase[p]    = 1;
      frame_idx[p]++;
      frames_left[p]--;
   endtask

   // Advance one source by one cycle, given which handshakes it completed.
   // phase: 0 gap, 1 header offered, 2 payload.
   task automatic applyStimulus(input int p, input bit hs_hdr, input bit hs_beat);
      case (phase[p])
         0: begin
            if (gap[p] > 0) begin
               gap[p]--;
            end else if (frames_left[p] > 0) begin
               startFrame(p);
            end
         end
         1: begin
            if (hs_hdr) begin
               drv_hv[p] = 1'b0;
               phase[p]  = 2;
               nextBeat(p);
            end
         end
         default: begin
            if (hs_beat) begin
               void'(cur_q[p].pop_front());
               if (cur_q[p].size() == 0) begin
                  drv_tv[p] = 1'b0;
                  drv_tl[p] = 1'b0;
                  drv_tu[p] = 1'b0;
                  phase[p]  = 0;
                  gap[p]    = $urandom_range(3);
               end else begin
                  nextBeat(p);
               end
            end else if (!drv_tv[p]) begin
               nextBeat(p);
            end
         end
      endcase
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mon_en = 1'b0;
      stim_done = 1'b0;
      stim_ok = 1'b0;
      post_last = 1'b0;
      for (int p = 0; p < 2; p++) begin
         drv_hv[p] = 1'b0; drv_dest[p] = '0; drv_src[p] = '0; drv_type[p] = '0;
         drv_data[p] = '0; drv_tv[p] = 1'b0; drv_tl[p] = 1'b0; drv_tu[p] = 1'b0;
         phase[p] = 0; gap[p] = 0; frames_left[p] = NFRAMES; frame_idx[p] = 0;
         done_cnt[p] = 0;
      end
      last_winner = 1;
      m_eth_hdr_ready = 1'b1;
      m_eth_payload_axis_tready = 1'b1;

      // Reset state, with the master readies high so gating is visible
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state",
         {grant, busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid,
          m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
          s0_eth_hdr_ready, s1_eth_hdr_ready, s0_eth_payload_axis_tready,
          s1_eth_payload_axis_tready, frame_cnt0, frame_cnt1}, '0);

      // Lone s1 request: one cycle of arbitration latency, then the grant
      @(posedge clk); #1;
      rst = 1'b0;
      drv_hv[1]   = 1'b1;
      drv_dest[1] = 48'h0A0B0C0D0E0F;
      drv_src[1]  = 48'h112233445566;
      drv_type[1] = 16'h88B5;
      @(negedge clk);
      checkOutput("arb_latency_idle", {grant, m_eth_hdr_valid}, 3'b000);
      @(negedge clk);
      checkOutput("arb_latency_grant",
         {grant, m_eth_hdr_valid, s1_eth_hdr_ready, s0_eth_hdr_ready, m_eth_type},
         {2'b10, 1'b1, 1'b1, 1'b0, 16'h88B5});
      @(posedge clk); #1;
      drv_hv[1]   = 1'b0;
      drv_tv[1]   = 1'b1;
      drv_data[1] = 8'd0;

      // Ten beats pass straight through, then reset lands on beat 10
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("passthru_beat",
            {m_eth_payload_axis_tvalid, s1_eth_payload_axis_tready, m_eth_payload_axis_tdata},
            {1'b1, 1'b1, 8'(k)});
         @(posedge clk); #1;
         drv_data[1] = 8'(k + 1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drv_tv[1] = 1'b0;
      @(negedge clk);
      checkOutput("mid_frame_reset",
         {grant, busy, m_eth_hdr_valid, m_eth_payload_axis_tvalid,
          s0_eth_hdr_ready, s1_eth_hdr_ready, s0_eth_payload_axis_tready,
          s1_eth_payload_axis_tready, frame_cnt0, frame_cnt1}, '0);

      // Random traffic from both sources, checked by the monitor
      mon_en = 1'b1;
      fork
         begin : stim
            bit hs_hdr[2];
            bit hs_beat[2];
            for (int cyc = 0; cyc < STIM_MAX; cyc++) begin
               @(negedge clk);
               hs_hdr[0]  = drv_hv[0] && s0_eth_hdr_ready;
               hs_hdr[1]  = drv_hv[1] && s1_eth_hdr_ready;
               hs_beat[0] = drv_tv[0] && s0_eth_payload_axis_tready;
               hs_beat[1] = drv_tv[1] && s1_eth_payload_axis_tready;
               @(posedge clk); #1;
               for (int p = 0; p < 2; p++) begin
                  applyStimulus(p, hs_hdr[p], hs_beat[p]);
               end
               m_eth_hdr_ready = ($urandom_range(3) != 0);
               if (cyc < 300) begin
                  m_eth_payload_axis_tready = ~m_eth_payload_axis_tready;
               end else begin
                  m_eth_payload_axis_tready = ($urandom_range(9) < 7);
               end
               if (frames_left[0] == 0 && frames_left[1] == 0 &&
                   phase[0] == 0 && phase[1] == 0) begin
                  stim_ok = 1'b1;
                  break;
               end
            end
            stim_done = 1'b1;
         end

         begin : monitor
            bit            arb_pending;
            bit            hdr_done;
            logic [1:0]    arb_exp;
            int            w;
            int            gp;
            int            lp;
            hdr_t          eh;
            logic [DW+1:0] eb;
            arb_pending = 1'b0;
            hdr_done    = 1'b0;
            arb_exp     = 2'b00;
            lp          = 0;
            forever begin
               @(negedge clk);
               if (mon_en) begin
                  // The cycle after a tlast beat is idle and shows the new count
                  if (post_last) begin
                     checkOutput("gap_idle", {busy, grant}, 3'b000);
                     checkOutput(lp == 0 ? "frame_cnt0" : "frame_cnt1",
                                 lp == 0 ? frame_cnt0 : frame_cnt1, done_cnt[lp] % CNT_MOD);
                     post_last = 1'b0;
                  end
                  if (arb_pending) begin
                     checkOutput("arb_grant", {grant, m_eth_hdr_valid}, {arb_exp, 1'b1});
                     arb_pending = 1'b0;
                  end else if (!busy) begin
                     checkOutput("idle_quiet",
                        {grant, m_eth_hdr_valid, m_eth_payload_axis_tvalid,
                         s0_eth_hdr_ready, s1_eth_hdr_ready,
                         s0_eth_payload_axis_tready, s1_eth_payload_axis_tready}, '0);
                     if (s0_eth_hdr_valid || s1_eth_hdr_valid) begin
`ifdef ETH_ARB_ROUND_ROBIN_EN
                        if (s0_eth_hdr_valid && s1_eth_hdr_valid) begin
                           w = 1 - last_winner;
                        end else begin
                           w = s0_eth_hdr_valid ? 0 : 1;
                        end
`else
                        w = s0_eth_hdr_valid ? 0 : 1;
`endif
                        arb_exp     = (w == 0) ? 2'b01 : 2'b10;
                        arb_pending = 1'b1;
                        hdr_done    = 1'b0;
                     end
                  end
                  if (busy) begin
                     gp = grant[1] ? 1 : 0;
                     checkOutput("nongrant_quiet",
                        {(grant == 2'b01) || (grant == 2'b10),
                         (gp == 0) ? {s1_eth_hdr_ready, s1_eth_payload_axis_tready}
                                   : {s0_eth_hdr_ready, s0_eth_payload_axis_tready}},
                        3'b100);
                     if (!hdr_done) begin
                        checkOutput("hdr_phase_quiet",
                           {m_eth_payload_axis_tvalid,
                            (gp == 0) ? s0_eth_payload_axis_tready : s1_eth_payload_axis_tready},
                           2'b00);
                     end
                     if (m_eth_hdr_valid && m_eth_hdr_ready) begin
                        checkOutput("hdr_expected", exp_hdr_q[gp].size() != 0, 1'b1);
                        if (exp_hdr_q[gp].size() != 0) begin
                           eh = exp_hdr_q[gp].pop_front();
                           checkOutput("hdr_fields", {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, eh);
                        end
                        hdr_done = 1'b1;
                     end else if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready) begin
                        checkOutput("beat_expected", exp_pay_q[gp].size() != 0, 1'b1);
                        if (exp_pay_q[gp].size() != 0) begin
                           eb = exp_pay_q[gp].pop_front();
                           checkOutput("beat",
                              {m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
                               m_eth_payload_axis_tdata}, eb);
                        end
                        if (m_eth_payload_axis_tlast) begin
                           done_cnt[gp]++;
                           last_winner = gp;
                           lp          = gp;
                           post_last   = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      join_none

      // Wait, with a bound, for all frames to drain through the monitor
      begin
         int waitc;
         waitc = 0;
         while (!(stim_done && exp_hdr_q[0].size() == 0 && exp_hdr_q[1].size() == 0 &&
                  exp_pay_q[0].size() == 0 && exp_pay_q[1].size() == 0) &&
                waitc < STIM_MAX + DRAIN_MAX) begin
            @(negedge clk);
            waitc++;
         end
         checkOutput("drain_in_time", waitc < STIM_MAX + DRAIN_MAX, 1'b1);
      end
      repeat (4) @(negedge clk);
      checkOutput("all_frames_issued", stim_ok, 1'b1);
      checkOutput("frames_seen0", done_cnt[0], NFRAMES);
      checkOutput("frames_seen1", done_cnt[1], NFRAMES);
      checkOutput("final_cnt", {frame_cnt0, frame_cnt1},
                  {CW'(NFRAMES % CNT_MOD), CW'(NFRAMES % CNT_MOD)});
      checkOutput("final_idle", {busy, grant}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
